pll_lock_sequencer: RTL

- Controls the core's fractional PLL (74.25 MHz refclk in; 40/32/4.19 MHz and phase-shifted 4.19 MHz out).
- Runs in the refclk domain. Drives the PLL reset, waits for lock with a timeout and retry, and debounces lock.
- Issues a single `ready` qualifier; downstream reset bridges for each PLL output domain consume it.
- Re-sequences the PLL on lock loss or on an explicit reinit request, e.g. after the bridge reconfigures the PLL.

---
 rtl/pll_ctrl_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/pll_lock_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer and its reset bridges.
package pll_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;

  typedef enum logic [STATE_W-1:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  // Width of a counter that must reach the largest of three cycle limits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for level signals crossing into the clk domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Resets the PLL, waits for a debounced lock with timeout/retry, and issues a
// single ready qualifier; re-sequences on lock loss or reinit_req.
module pll_lock_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 74250,
  parameter int LOCK_STABLE     = 1024,
  parameter int MAX_RETRIES     = 3
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               reinit_req,
  output logic               pll_rst,
  output logic               ready,
  output logic               fault,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [STATE_W-1:0] state
);

  localparam int CNT_W = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
  localparam bit                 RETRY_BOUND  = (MAX_RETRIES != 0);

  logic               locked_s;
  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               lock_lost_q, lock_lost_d;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  assign retry_inc = (retry_q == '1) ? retry_q : retry_q + 1'b1;

  // Next-state, counter and status bookkeeping. reinit_req overrides all
  // transitions; the counter restarts whenever the state changes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;

    if (reinit_req) begin
      state_d     = HOLD;
      cnt_d       = '0;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABILIZE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_inc;
            if (RETRY_BOUND && (retry_inc == RETRY_LIMIT)) state_d = FAULT;
            else                                           state_d = HOLD;
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            retry_d = '0;
          end
        end
        RUN: begin
          cnt_d = '0;
          if (!locked_s) begin
            state_d     = HOLD;
            lock_lost_d = 1'b1;
          end
        end
        FAULT: begin
          cnt_d = '0;
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end

    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs decode state_d so they move on the same edge as state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
      pll_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      pll_rst     <= (state_d == HOLD) || (state_d == FAULT);
      ready       <= (state_d == RUN);
      fault       <= (state_d == FAULT);
    end
  end

  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule
